// File: rtl/fixed_mul_pkg.sv
// Shared types, constants and the scale/saturate helper for the multiplier scheduler.
package fixed_mul_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  localparam logic [DATA_W-1:0] MAX_POS = 32'h7FFFFFFF;
  localparam logic [DATA_W-1:0] MAX_NEG = 32'h80000000;

  // Ownership tag that travels alongside each product through the multiplier latency.
  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } tag_t;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] data;
  } sat_res_t;

  // Arithmetic right shift by the fractional width, then clamp to the signed 32-bit range.
  // The value fits when bits [63:31] are all copies of the sign bit.
  function automatic sat_res_t sat_scale(input logic signed [PROD_W-1:0] product,
                                         input int unsigned frac_bits);
    logic signed [PROD_W-1:0] p;
    sat_res_t r;
    p      = product >>> frac_bits;
    r.sat  = 1'b0;
    r.data = p[DATA_W-1:0];
    if (p[PROD_W-1:DATA_W-1] != {(PROD_W-DATA_W+1){p[PROD_W-1]}}) begin
      r.sat  = 1'b1;
      r.data = p[PROD_W-1] ? MAX_NEG : MAX_POS;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] gidx;
  logic             found;

  // Rotating priority search; grant is suppressed while reset is asserted.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        gidx  = PTR_W'(j);
      end
    end
    if (found && !reset) grant[gidx] = 1'b1;
    ptr_nxt = (gidx == PTR_W'(N-1)) ? '0 : gidx + 1'b1;
  end

  // Pointer moves just past the winner on an accepted grant; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fixed_mul_sched.sv
// Shares one external signed 32x32 multiplier among N requesters, tagging each product
// with its owner and returning a scaled, saturated result in issue order.
module fixed_mul_sched import fixed_mul_pkg::*; #(
  parameter int N         = 4,
  parameter int MUL_LAT   = 0,
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N*DATA_W-1:0] req_a,
  input  logic [N*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]   mul_dataa,
  output logic [DATA_W-1:0]   mul_datab,
  input  logic [PROD_W-1:0]   mul_result,
  output logic [N-1:0]        rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_sat,
  output logic [3:0]          inflight
);

  logic [N-1:0]      grant;
  logic              hs;
  logic [2:0]        gidx;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  tag_t              tag_p [0:MUL_LAT];
  tag_t              tag_out;
  sat_res_t          res;
  logic [N-1:0]      owner_oh;

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (hs),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);

  // Encode the one-hot grant and select the winner's operands.
  always_comb begin
    gidx  = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = 3'(i);
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- stage p0: operand registers feeding the multiplier ----
  // Operands update only on an accepted grant so the multiplier inputs stay quiet when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_dataa <= '0;
      mul_datab <= '0;
    end else if (hs) begin
      mul_dataa <= a_sel;
      mul_datab <= b_sel;
    end
  end

  // Tag pipeline mirrors the multiplier depth; reset discards every in-flight owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= MUL_LAT; k++) tag_p[k] <= '0;
    end else begin
      tag_p[0] <= tag_t'{vld: hs, idx: gidx};
      for (int k = 1; k <= MUL_LAT; k++) tag_p[k] <= tag_p[k-1];
    end
  end

  // ---- retire stage: product aligned with tag_p[MUL_LAT] ----
  assign tag_out = tag_p[MUL_LAT];
  assign res     = sat_scale(mul_result, FRAC_BITS);

  // Decode the owner index into a one-hot response vector.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (tag_out.vld && (tag_out.idx == 3'(i))) owner_oh[i] = 1'b1;
    end
  end

  // Register the response; data and flag hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_sat   <= 1'b0;
    end else begin
      rsp_valid <= owner_oh;
      if (tag_out.vld) begin
        rsp_data <= res.data;
        rsp_sat  <= res.sat;
      end
    end
  end

  // Outstanding-operation counter: issue and retire in the same cycle cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({hs, tag_out.vld})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
